// File: rtl/mux_arb_rr.sv
// N-input, W-bit round-robin arbitrated mux with valid/ready handshakes and a one-entry output buffer.
// Optional per-input saturating grant counters on port grant_count when MUX_ARB_RR_STATS_EN is defined.
module mux_arb_rr #(
    parameter int p_nbits = 8,
    parameter int p_ninputs = 4,
    localparam int c_sel_nbits = $clog2(p_ninputs)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_ninputs-1:0]           in_val,
    output logic [p_ninputs-1:0]           in_rdy,
    input  logic [p_ninputs*p_nbits-1:0]   in_msg,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_nbits-1:0]             out_msg,
`ifdef MUX_ARB_RR_STATS_EN
    output logic [p_ninputs*16-1:0]        grant_count,
`endif
    output logic [c_sel_nbits-1:0]         out_sel
);

    localparam logic [c_sel_nbits-1:0] c_last = c_sel_nbits'(p_ninputs - 1);

    logic [c_sel_nbits-1:0] ptr;
    logic [p_ninputs-1:0]   grant_p0;
    logic [c_sel_nbits-1:0] idx_p0;
    logic [c_sel_nbits-1:0] cand_p0;
    logic                   any_p0;
    logic [p_nbits-1:0]     msg_p0;
    logic                   can_accept;
    logic                   xfer_p0;

    logic                   vld_p1;
    logic [p_nbits-1:0]     msg_p1;
    logic [c_sel_nbits-1:0] sel_p1;

    // Index k positions after the pointer; explicit wrap keeps non-power-of-two N in range.
    function automatic logic [c_sel_nbits-1:0] rot_idx(input logic [c_sel_nbits-1:0] base,
                                                      input int k);
        int s;
        s = int'(base) + k;
        if (s >= p_ninputs) begin
            s = s - p_ninputs;
        end
        return c_sel_nbits'(s);
    endfunction

    function automatic logic [c_sel_nbits-1:0] next_ptr(input logic [c_sel_nbits-1:0] i);
        return (i == c_last) ? '0 : i + c_sel_nbits'(1);
    endfunction

    // ---- stage p0: combinational arbitration and payload select ----
    always_comb begin
        grant_p0 = '0;
        idx_p0   = '0;
        cand_p0  = '0;
        any_p0   = 1'b0;
        for (int k = 0; k < p_ninputs; k++) begin
            cand_p0 = rot_idx(ptr, k);
            if (!any_p0 && in_val[cand_p0]) begin
                any_p0 = 1'b1;
                idx_p0 = cand_p0;
            end
        end
        grant_p0[idx_p0] = any_p0;
    end

    always_comb begin
        msg_p0 = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            if (idx_p0 == c_sel_nbits'(i)) begin
                msg_p0 = in_msg[i*p_nbits +: p_nbits];
            end
        end
    end

    assign can_accept = !vld_p1 || out_rdy;
    assign xfer_p0    = any_p0 && can_accept && !reset;
    assign in_rdy     = grant_p0 & {p_ninputs{can_accept && !reset}};

    // ---- stage p1: one-entry output buffer ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            msg_p1 <= '0;
            sel_p1 <= '0;
            ptr    <= '0;
        end else if (xfer_p0) begin
            vld_p1 <= 1'b1;
            msg_p1 <= msg_p0;
            sel_p1 <= idx_p0;
            ptr    <= next_ptr(idx_p0);
        end else if (vld_p1 && out_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_val = vld_p1;
    assign out_msg = msg_p1;
    assign out_sel = sel_p1;

`ifdef MUX_ARB_RR_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < p_ninputs; i++) begin
                if (xfer_p0 && grant_p0[i]) begin
                    grant_count[i*16 +: 16] <= sat_inc(grant_count[i*16 +: 16]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_rr.sv
// Scoreboard bench for mux_arb_rr: N=4 main instance driven by a queue-based reference model,
// plus an N=3 instance for non-power-of-two wrap. Stats checks compile in with MUX_ARB_RR_STATS_EN.
module tb_mux_arb_rr;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_val;
    logic [N-1:0]   in_rdy;
    logic [N*W-1:0] in_msg;
    logic           out_val;
    logic           out_rdy;
    logic [W-1:0]   out_msg;
    logic [1:0]     out_sel;

    logic [2:0]     v3;
    logic [2:0]     rdy3;
    logic [23:0]    m3;
    logic           oval3;
    logic [7:0]     omsg3;
    logic [1:0]     osel3;
`ifdef MUX_ARB_RR_STATS_EN
    logic [N*16-1:0] grant_count;
    logic [47:0]     gc3;
`endif

    mux_arb_rr #(.p_nbits(W), .p_ninputs(N)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
`ifdef MUX_ARB_RR_STATS_EN
        .grant_count(grant_count),
`endif
        .out_sel(out_sel)
    );

    mux_arb_rr #(.p_nbits(8), .p_ninputs(3)) dut3 (
        .clk(clk), .reset(reset), .in_val(v3), .in_rdy(rdy3), .in_msg(m3),
        .out_val(oval3), .out_rdy(1'b1), .out_msg(omsg3),
`ifdef MUX_ARB_RR_STATS_EN
        .grant_count(gc3),
`endif
        .out_sel(osel3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] msg;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ptr  = 0;
    bit   m_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid index scanning upward from p, modulo N.
    function automatic int pick(input logic [3:0] v, input int p);
        logic [1:0] ix;
        for (int k = 0; k < N; k++) begin
            ix = 2'((p + k) % N);
            if (v[ix]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] m, input logic ordy, input logic rst);
        int         g;
        logic [3:0] exp_rdy;
        logic [1:0] gi;
        exp_t       e;
        @(posedge clk);
        #1;
        in_val  = v;
        in_msg  = m;
        out_rdy = ordy;
        reset   = rst;
        #1;
        chk("out_val", 32'(out_val), 32'(m_full));
        g       = pick(v, m_ptr);
        exp_rdy = 4'b0000;
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb.delete();
        end else if (g >= 0 && (!m_full || ordy)) begin
            gi          = 2'(g);
            exp_rdy[gi] = 1'b1;
            e.sel       = g;
            e.msg       = 8'(m >> (8 * g));
            sb.push_back(e);
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (ordy) begin
            m_full = 1'b0;
        end
        chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    endtask

    // Monitor: every output handshake must match the oldest expected message.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_val === 1'b1 && out_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got msg %0h sel %0d expected no delivery", out_msg, out_sel);
                end else begin
                    e = sb.pop_front();
                    chk("out_sel", 32'(out_sel), 32'(e.sel));
                    chk("out_msg", 32'(out_msg), 32'(e.msg));
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        in_val  = '0;
        in_msg  = '0;
        out_rdy = 1'b1;
        v3      = '0;
        m3      = 24'hC2C1C0;

        // Reset with every requester valid
        drive(4'hF, 32'hA3A2A1A0, 1'b1, 1'b1);
        drive(4'hF, 32'hA3A2A1A0, 1'b1, 1'b1);
        chk("rst_msg", 32'(out_msg), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);

        // Full-load round robin
        for (int j = 0; j < 7; j++) begin
            drive(4'hF, 32'hA3A2A1A0, 1'b1, 1'b0);
            if (j >= 1) begin
                chk("rr_sel", 32'(out_sel), 32'((j - 1) % 4));
                chk("rr_msg", 32'(out_msg), 32'(8'hA0 + 8'((j - 1) % 4)));
            end
        end

        // Backpressure: hold 0x5C from input 2
        drive(4'b0100, 32'h005C0000, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            drive(4'b1000, 32'hD35C0000, 1'b0, 1'b0);
            chk("bp_msg", 32'(out_msg), 32'h5C);
            chk("bp_sel", 32'(out_sel), 32'h2);
            chk("bp_rdy", 32'(in_rdy), 32'h0);
        end
        drive(4'b1000, 32'hD35C0000, 1'b1, 1'b0);
        chk("bp_next", 32'(in_rdy), 32'b1000);
        drive(4'b0000, 32'h0, 1'b1, 1'b0);

        // N=3 sparse wrap
        v3 = 3'b100;
        #1;
        chk("n3_g2", 32'(rdy3), 32'b100);
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        v3 = 3'b011;
        #1;
        chk("n3_g0", 32'(rdy3), 32'b001);
        chk("n3_sel2", 32'(osel3), 32'h2);
        chk("n3_msg2", 32'(omsg3), 32'hC2);
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        v3 = 3'b110;
        #1;
        chk("n3_sel0", 32'(osel3), 32'h0);
        chk("n3_g1", 32'(rdy3), 32'b010);
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        v3 = 3'b000;

        // Reset while FULL discards the buffered message
        drive(4'b0001, 32'h00000077, 1'b1, 1'b0);
        drive(4'b0000, 32'h0, 1'b0, 1'b0);
        chk("mid_msg", 32'(out_msg), 32'h77);
        drive(4'hF, 32'hA3A2A1A0, 1'b0, 1'b1);
        drive(4'hF, 32'hA3A2A1A0, 1'b1, 1'b0);
        chk("mid_flush", 32'(out_val), 32'h0);
        chk("mid_ptr0", 32'(in_rdy), 32'b0001);

        // Randomised traffic with occasional reset
        for (int j = 0; j < 400; j++) begin
            drive(4'($urandom), $urandom, 1'($urandom_range(3) != 0), 1'($urandom_range(63) == 0));
        end
        for (int j = 0; j < 3; j++) begin
            drive(4'b0000, 32'h0, 1'b1, 1'b0);
        end
        chk("drained", 32'(sb.size()), 32'h0);

`ifdef MUX_ARB_RR_STATS_EN
        drive(4'b0000, 32'h0, 1'b1, 1'b1);
        for (int j = 0; j < 10; j++) begin
            drive(4'b0010, 32'h00001100, 1'b1, 1'b0);
        end
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("cnt1_10", 32'(grant_count[31:16]), 32'd10);
        chk("cnt0_0", 32'(grant_count[15:0]), 32'd0);
        chk("cnt23_0", grant_count[63:32], 32'd0);
        for (int j = 0; j < 65530; j++) begin
            drive(4'b0010, 32'h00001100, 1'b1, 1'b0);
        end
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("cnt1_sat", 32'(grant_count[31:16]), 32'hFFFF);
        drive(4'b0000, 32'h0, 1'b1, 1'b1);
        drive(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("cnt_clr", 32'(grant_count[31:16]), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
